// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared widths, state encoding and gate-timing defaults
// for the dead-time PWM capture block and the generator it watches.
`timescale 1ns/1ps
package pwm_capture_pkg;

    localparam int CW = 16;

    typedef logic [CW-1:0] cnt_t;

    // Same dead time the generator inserts between Hi and Lo.
    localparam cnt_t DEAD_MIN_DEF = 16'h00f0;
    localparam cnt_t TIMEOUT_DEF  = 16'hfff0;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    // Counters stick at all-ones rather than wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchronizer for one asynchronous gate line plus a
// delay flop; outputs the synced level and single-cycle rise/fall pulses.
// Ports: clk_i, rst_ni (async, active-low), d_i (async line),
//        s_o (synced level), rise_o, fall_o.
`timescale 1ns/1ps
module pwm_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic s_q;
    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
            d_q    <= 1'b0;
        end else begin
            meta_q <= d_i;
            s_q    <= meta_q;
            d_q    <= s_q;
        end
    end

    assign s_o    = s_q;
    assign rise_o = s_q & ~d_q;
    assign fall_o = ~s_q & d_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high-side on-time and both dead-time gaps of
// a complementary gate pair; flags shoot-through, short dead time and stall.
// Ports: CLK, RST_N (async, active-low), Hi_in/Lo_in (async gate lines),
//        Clr (clears sticky flags); Period, HiWidth, DeadRise, DeadFall
//        (16-bit cycle counts), Valid strobe, Shoot/DeadErr/Stall flags.
`timescale 1ns/1ps
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter cnt_t DEAD_MIN = DEAD_MIN_DEF,
    parameter cnt_t TIMEOUT  = TIMEOUT_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Hi_in,
    input  logic          Lo_in,
    input  logic          Clr,
    output logic [CW-1:0] Period,
    output logic [CW-1:0] HiWidth,
    output logic [CW-1:0] DeadRise,
    output logic [CW-1:0] DeadFall,
    output logic          Valid,
    output logic          Shoot,
    output logic          DeadErr,
    output logic          Stall
);

    logic h_s, h_rise, h_fall;
    logic l_s, l_rise, l_fall;

    pwm_sync_edge u_hi (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (Hi_in),
        .s_o    (h_s),
        .rise_o (h_rise),
        .fall_o (h_fall)
    );

    pwm_sync_edge u_lo (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (Lo_in),
        .s_o    (l_s),
        .rise_o (l_rise),
        .fall_o (l_fall)
    );

    state_e st_q;
    cnt_t   per_cnt_q, hi_cnt_q, dr_cnt_q, df_cnt_q;
    cnt_t   period_q, hiw_q, dr_q, df_q;
    logic   valid_q, shoot_q, derr_q, stall_q;

    // A dead-time counter of zero means "not armed": no matching edge on
    // the other line since the last measurement, so nothing is latched.
    logic both_lo, hr_meas, dr_take, df_take;
    logic derr_set, stall_set, shoot_set;
    cnt_t dr_val, df_val;

    assign both_lo   = ~h_s & ~l_s;
    assign hr_meas   = h_rise & (st_q == MEAS);
    assign dr_val    = l_fall ? '0 : dr_cnt_q;
    assign df_val    = h_fall ? '0 : df_cnt_q;
    assign dr_take   = hr_meas & (l_fall | (dr_cnt_q != '0));
    assign df_take   = l_rise & (st_q == MEAS)
                     & (h_fall | (df_cnt_q != '0));
    assign derr_set  = (dr_take & (dr_val < DEAD_MIN))
                     | (df_take & (df_val < DEAD_MIN));
    assign stall_set = (st_q == MEAS) & ~h_rise
                     & (per_cnt_q >= TIMEOUT);
    assign shoot_set = h_s & l_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q      <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            dr_cnt_q  <= '0;
            df_cnt_q  <= '0;
            period_q  <= '0;
            hiw_q     <= '0;
            dr_q      <= '0;
            df_q      <= '0;
            valid_q   <= 1'b0;
            shoot_q   <= 1'b0;
            derr_q    <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            per_cnt_q <= sat_inc(per_cnt_q);
            if (h_s) hi_cnt_q <= sat_inc(hi_cnt_q);

            if (l_fall)
                dr_cnt_q <= 16'd1;
            else if (both_lo && dr_cnt_q != '0)
                dr_cnt_q <= sat_inc(dr_cnt_q);

            if (h_fall)
                df_cnt_q <= 16'd1;
            else if (both_lo && df_cnt_q != '0)
                df_cnt_q <= sat_inc(df_cnt_q);

            if (hr_meas) begin
                period_q <= per_cnt_q;
                hiw_q    <= hi_cnt_q;
                valid_q  <= 1'b1;
            end
            if (dr_take) dr_q <= dr_val;
            if (df_take) df_q <= df_val;

            // A Hi rise consumes the low->high gap; a Lo rise the other.
            if (h_rise) begin
                per_cnt_q <= 16'd1;
                hi_cnt_q  <= 16'd1;
                dr_cnt_q  <= '0;
                st_q      <= MEAS;
            end
            if (l_rise) df_cnt_q <= '0;

            if (stall_set) begin
                st_q     <= IDLE;
                dr_cnt_q <= '0;
                df_cnt_q <= '0;
            end

            shoot_q <= shoot_set | (shoot_q & ~Clr);
            derr_q  <= derr_set  | (derr_q  & ~Clr);
            stall_q <= stall_set | (stall_q & ~Clr);
        end
    end

    assign Period   = period_q;
    assign HiWidth  = hiw_q;
    assign DeadRise = dr_q;
    assign DeadFall = df_q;
    assign Valid    = valid_q;
    assign Shoot    = shoot_q;
    assign DeadErr  = derr_q;
    assign Stall    = stall_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed gate-pair waveforms against a timestamp-based
// model of the capture rules, plus literal checks of key measurements.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam logic [15:0] DMIN = 16'h00f0;
    localparam logic [15:0] TOUT = 16'hfff0;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Hi_in = 1'b0;
    logic        Lo_in = 1'b0;
    logic        Clr = 1'b0;
    logic [15:0] Period, HiWidth, DeadRise, DeadFall;
    logic        Valid, Shoot, DeadErr, Stall;

    pwm_capture #(.DEAD_MIN(DMIN), .TIMEOUT(TOUT)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Hi_in    (Hi_in),
        .Lo_in    (Lo_in),
        .Clr      (Clr),
        .Period   (Period),
        .HiWidth  (HiWidth),
        .DeadRise (DeadRise),
        .DeadFall (DeadFall),
        .Valid    (Valid),
        .Shoot    (Shoot),
        .DeadErr  (DeadErr),
        .Stall    (Stall)
    );

    always #5 CLK = ~CLK;

    // ---------------- model ----------------
    // Line values seen at the last four edges; a gate edge becomes
    // visible to the measurement logic two edges after it is sampled.
    bit [3:0]    hp, lp;
    int          t;
    int          rise_t, hf_t, dr_from, df_from;
    bit          meas;
    logic [15:0] m_per, m_hiw, m_dr, m_df;
    bit          m_valid, m_shoot, m_derr, m_stall;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hffff : v[15:0];
    endfunction

    always @(posedge CLK) begin
        bit hs, hd, ls, ld, hr, hf, lr, lf, was, e_err, e_stall;
        t = t + 1;
        if (!RST_N) begin
            hp = '0; lp = '0; meas = 0;
            rise_t = 0; hf_t = -1; dr_from = -1; df_from = -1;
            m_per = '0; m_hiw = '0; m_dr = '0; m_df = '0;
            m_valid = 0; m_shoot = 0; m_derr = 0; m_stall = 0;
        end else begin
            hp = {hp[2:0], Hi_in};
            lp = {lp[2:0], Lo_in};
            hs = hp[2]; hd = hp[3]; ls = lp[2]; ld = lp[3];
            hr = hs & ~hd; hf = ~hs & hd;
            lr = ls & ~ld; lf = ~ls & ld;
            was = meas; m_valid = 0; e_err = 0; e_stall = 0;
            if (hr) begin
                if (was) begin
                    m_per = sat16(t - rise_t);
                    m_hiw = sat16((hf_t > rise_t) ? hf_t - rise_t
                                                  : t - rise_t);
                    m_valid = 1;
                    if (lf) begin
                        m_dr = '0; e_err = 1;
                    end else if (dr_from >= 0) begin
                        m_dr = sat16(t - dr_from);
                        if (m_dr < DMIN) e_err = 1;
                    end
                end
                rise_t = t; meas = 1; dr_from = -1;
            end else if (lf) begin
                dr_from = t;
            end
            if (lr) begin
                if (was) begin
                    if (hf) begin
                        m_df = '0; e_err = 1;
                    end else if (df_from >= 0) begin
                        m_df = sat16(t - df_from);
                        if (m_df < DMIN) e_err = 1;
                    end
                end
                df_from = -1;
            end else if (hf) begin
                df_from = t;
            end
            if (hf) hf_t = t;
            if (was && !hr && (t - rise_t) == int'(TOUT)) begin
                e_stall = 1; meas = 0; dr_from = -1; df_from = -1;
            end
            m_shoot = (hs & ls) | (m_shoot & ~Clr);
            m_derr  = e_err     | (m_derr  & ~Clr);
            m_stall = e_stall   | (m_stall & ~Clr);
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    int nvalid = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at t=%0d: got %0d expected %0d",
                         nm, t, act, exp);
        end
    endtask

    task automatic seg(input bit h, input bit l, input int n,
                       input bit c = 0);
        Hi_in = h; Lo_in = l; Clr = c;
        @(negedge CLK);
        Clr = 0;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic pwm(input int hi, input int gf, input int lo,
                       input int gr, input int n, input bit c = 0);
        for (int i = 0; i < n; i++) begin
            seg(1, 0, hi);
            seg(0, 0, gf);
            seg(0, 1, lo, (i == 0) ? c : 1'b0);
            seg(0, 0, gr);
        end
    endtask

    initial begin
        int v0;
        fork
            forever begin
                @(negedge CLK);
                if (chk_en && RST_N) begin
                    if (Valid) nvalid++;
                    chk("period",   Period,   m_per);
                    chk("hiwidth",  HiWidth,  m_hiw);
                    chk("deadrise", DeadRise, m_dr);
                    chk("deadfall", DeadFall, m_df);
                    chk("valid",    Valid,    m_valid);
                    chk("shoot",    Shoot,    m_shoot);
                    chk("deaderr",  DeadErr,  m_derr);
                    chk("stall",    Stall,    m_stall);
                end
            end
        join_none

        repeat (3) @(negedge CLK);
        chk("rst_period", Period, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_flags", {Shoot, DeadErr, Stall}, 0);
        RST_N = 1;
        chk_en = 1;
        seg(0, 0, 5);

        // steady PWM
        v0 = nvalid;
        pwm(400, 240, 1200, 240, 3);
        chk("steady_valids", nvalid - v0, 2);
        chk("steady_period", Period, 2080);
        chk("steady_hiw", HiWidth, 400);
        chk("steady_dr", DeadRise, 16'h00f0);
        chk("steady_df", DeadFall, 16'h00f0);
        chk("steady_err", DeadErr, 0);

        // short dead time, then restore and clear
        pwm(100, 16, 300, 16, 3);
        chk("short_period", Period, 432);
        chk("short_dr", DeadRise, 16'h0010);
        chk("short_df", DeadFall, 16'h0010);
        chk("short_err", DeadErr, 1);
        pwm(100, 240, 300, 240, 3, 1);
        chk("restore_err", DeadErr, 0);
        chk("restore_dr", DeadRise, 240);
        chk("restore_period", Period, 880);

        // overlap: both high for 3 cycles
        seg(1, 0, 100);
        seg(1, 1, 3);
        seg(0, 1, 297);
        seg(0, 0, 240);
        seg(1, 0, 10);
        chk("ovl_hiw", HiWidth, 103);
        chk("ovl_period", Period, 640);
        seg(0, 0, 240);
        seg(0, 1, 300);
        seg(0, 0, 240);
        pwm(100, 240, 300, 240, 2);
        chk("ovl_shoot_held", Shoot, 1);
        chk("ovl_period2", Period, 880);
        pwm(100, 240, 300, 240, 1, 1);
        chk("ovl_shoot_clr", Shoot, 0);

        // stall
        seg(0, 0, int'(TOUT));
        chk("stall_set", Stall, 1);
        chk("stall_hold_per", Period, 880);
        chk("stall_hold_hiw", HiWidth, 100);
        v0 = nvalid;
        pwm(100, 240, 300, 240, 1);
        chk("stall_first_rise", nvalid - v0, 0);
        pwm(100, 240, 300, 240, 1, 1);
        chk("stall_second_rise", nvalid - v0, 1);
        chk("stall_period", Period, 880);
        chk("stall_clr", Stall, 0);

        // reset during Hi high
        seg(1, 0, 50);
        #2 RST_N = 0;
        #1;
        chk("arst_period", Period, 0);
        chk("arst_hiw", HiWidth, 0);
        chk("arst_dead", {DeadRise, DeadFall}, 0);
        chk("arst_valid", Valid, 0);
        Hi_in = 0; Lo_in = 0;
        repeat (3) @(negedge CLK);
        RST_N = 1;
        seg(0, 0, 5);
        v0 = nvalid;
        pwm(100, 240, 300, 240, 2);
        chk("arst_valids", nvalid - v0, 1);
        chk("arst_period2", Period, 880);
        chk("arst_dr", DeadRise, 240);

        // simultaneous edges
        seg(1, 0, 100);
        seg(0, 0, 240);
        seg(0, 1, 300);
        seg(1, 0, 100);
        chk("sim_dr", DeadRise, 0);
        chk("sim_err", DeadErr, 1);
        chk("sim_period", Period, 640);
        seg(0, 1, 300);
        chk("sim_df", DeadFall, 0);
        seg(0, 0, 240);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Measures the complementary gate pair driven by the center-aligned dead-time PWM generator: period, high-side on-time and both dead-time gaps.
- Flags shoot-through, dead-time violations and a stalled carrier.
- Sits on the gate-pin side, either as a loop-back monitor in the same FPGA or on a second board reading the gate lines.
- Results go to the control/CPU side as 16-bit cycle counts with a one-cycle valid strobe.

## Interface
- DEAD_MIN, 16'h00f0: minimum legal dead time in CLK cycles; same value as the generator's dead time.
- TIMEOUT, 16'hfff0: cycles without a high-side rising edge before Stall asserts.
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- Hi_in  in  1  high-side gate line; asynchronous to CLK.
- Lo_in  in  1  low-side gate line; asynchronous to CLK.
- Clr  in  1  synchronous, active-high; clears the sticky Shoot, DeadErr and Stall flags.
- Period  out  16  cycles between the last two high-side rising edges.
- HiWidth  out  16  high-side on-time of the last completed period.
- DeadRise  out  16  cycles from the Lo falling edge to the following Hi rising edge.
- DeadFall  out  16  cycles from the Hi falling edge to the following Lo rising edge.
- Valid  out  1  one-cycle strobe: Period, HiWidth and DeadRise have just updated.
- Shoot  out  1  sticky: Hi and Lo were seen high together.
- DeadErr  out  1  sticky: a measured dead time was < DEAD_MIN.
- Stall  out  1  sticky: no Hi rising edge for TIMEOUT cycles.

## Operation
- **Input sync and edge detect:** each input passes through a 2-flop synchronizer (h_s, l_s). A delayed copy (h_d, l_d) gives the edges: rise = s & ~d, fall = ~s & d.
- **States:** IDLE and MEAS. IDLE → MEAS on the first Hi rise; no Valid is issued for that edge. MEAS → IDLE on Stall.
- **Counters:** PerCnt, HiCnt, DrCnt, DfCnt, all 16-bit, incrementing and saturating at 16'hffff (no wrap).
- **Hi rise in MEAS:**
  - Period <= PerCnt; HiWidth <= HiCnt; DeadRise <= DrCnt; Valid <= 1.
  - PerCnt <= 1; HiCnt <= 1.
- **Hi rise in IDLE:** PerCnt <= 1; HiCnt <= 1; no output update.
- **HiCnt:** increments while h_s = 1 and holds while h_s = 0.
- **Low→high dead time:** DrCnt clears to 1 on Lo fall and increments while both synced lines are low. DeadRise latches DrCnt on Hi rise.
- **High→low dead time:** DfCnt clears to 1 on Hi fall and increments while both synced lines are low. On Lo rise, DeadFall <= DfCnt; no Valid strobe.
- **DeadErr:** set when DeadRise or DeadFall is latched with a value < DEAD_MIN. The first Hi rise out of IDLE is not checked.
- **Shoot:** set any cycle where h_s & l_s.
- **Stall:** set when PerCnt reaches TIMEOUT. Stall also forces IDLE; Period, HiWidth, DeadRise and DeadFall hold their last values.
- **Clr:** clears Shoot, DeadErr and Stall. If a set condition occurs in the same cycle, set wins.
- **Reset (RST_N low), asynchronous at any time, including mid-period:**
  - State IDLE.
  - All counters, data outputs and flags return to 0; Valid = 0.
  - Synchronizer flops return to 0.

## Timing
- Latency: a Hi_in edge meeting setup before CLK edge n is in h_s at edge n+1. Valid is high during the cycle after edge n+2.
- Valid is exactly one cycle wide and at most one per Hi rise.
- Measurements are exact in CLK cycles for inputs stable for ≥2 cycles. Input glitches shorter than 1 cycle may or may not be captured.
- Simultaneous Lo fall and Hi rise (DrCnt never counts): DeadRise <= 0 and DeadErr sets.
- Simultaneous Hi fall and Lo rise: DeadFall <= 0 and DeadErr sets.
- Lo never toggling: DeadRise/DeadFall keep their previous values and no DeadErr is produced from them.

## Structure
- Shared package: counter width (16), the state encoding (IDLE/MEAS), and the DEAD_MIN default shared with the generator.
- Sub-module: pwm_sync_edge, one instance per input. It contains the 2-flop synchronizer plus delay flop and outputs the s/rise/fall signals.
- Everything else is a single always block in pwm_capture, using async reset on negedge RST_N.

## Test plan
- **Steady PWM:** Hi high 400 cycles, Lo high 1200, 0x00f0 gaps each side, period 2080. From the second Hi rise: Period=2080, HiWidth=400, DeadRise=0x00f0, DeadFall=0x00f0, Valid once per period, DeadErr=0.
- **Short dead time:** gaps of 0x0010 → DeadRise=0x0010, DeadErr=1. Pulse Clr with gaps restored → DeadErr=0 and stays 0.
- **Overlap:** Hi and Lo both high for 3 cycles → Shoot=1, held through subsequent clean periods until Clr.
- **Stall:** freeze both inputs low for TIMEOUT (0xfff0) cycles. Stall=1, state IDLE, outputs hold. Next Hi rise gives no Valid; the one after it gives a correct Period.
- **Reset mid-period:** drop RST_N during Hi high. All outputs read 0 immediately (async). After release, the first Hi rise yields no Valid and the second yields a correct Period.
- **Simultaneous edges:** Lo fall and Hi rise in the same cycle → DeadRise=0, DeadErr=1.
